// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the generic pipeline-stage latch: occupancy encodings
// and the payload layout used by the instantiating stages to build in_data.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam int PC_W      = 32;
  localparam int INSTR_W   = 32;
  localparam int PAYLOAD_W = PC_W + INSTR_W;

  // addi x0, x0, 0 -- the canonical NOP placed in the instruction field of a bubble
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [PAYLOAD_W-1:0] bubble_payload(input logic [PC_W-1:0] pc);
    return {pc, NOP_INSTR};
  endfunction

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Occupancy FSM for the pipeline-stage latch: derives in_ready, out_valid and the
// load enables for the main/skid payload registers held in the top.
module pipe_skid_ctrl
  import pipe_stage_skid_pkg::*;
#(
  parameter int SKID = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  input  logic       stall,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic       in_ready,
  output logic       out_valid,
  output logic       load_main,
  output logic       main_from_skid,
  output logic       load_skid,
  output logic [1:0] occupancy
);

  occ_e state_q, state_d;
  logic in_ready_q, in_ready_d;
  logic in_fire, out_fire;

  assign out_valid = (state_q != OCC_EMPTY) && !stall;
  assign out_fire  = out_valid && out_ready;
  // Skid variant presents a pure flop; single-register variant may pass through a same-cycle drain.
  assign in_ready  = (SKID != 0) ? in_ready_q
                                 : (!reset && ((state_q == OCC_EMPTY) || out_fire));
  assign in_fire   = in_valid && in_ready;
  assign occupancy = state_q;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            state_d   = OCC_ONE;
            load_main = 1'b1;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            state_d   = OCC_TWO;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (out_fire) begin
            state_d        = OCC_ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
    in_ready_d = (state_d != OCC_TWO);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= OCC_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline-stage register with optional 2-entry skid buffer,
// stage-local stall/flush and bubble substitution on the output when empty.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int                DATA_W      = PAYLOAD_W,
  parameter int                SKID        = 1,
  parameter int                BUBBLE_ZERO = 1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL  = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy
);

  logic              load_main, main_from_skid, load_skid;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  pipe_skid_ctrl #(
    .SKID(SKID)
  ) u_ctrl (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .stall         (stall),
    .in_valid      (in_valid),
    .out_ready     (out_ready),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .load_main     (load_main),
    .main_from_skid(main_from_skid),
    .load_skid     (load_skid),
    .occupancy     (occupancy)
  );

  always_comb begin
    main_d = main_q;
    if (load_main) begin
      main_d = main_from_skid ? skid_q : in_data;
    end
    skid_d = load_skid ? in_data : skid_q;
  end

  // main resets to the bubble so a held-value stage still shows a NOP out of reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_q <= BUBBLE_VAL;
    end else begin
      main_q <= main_d;
    end
  end

  always_ff @(posedge clock) begin
    skid_q <= skid_d;
  end

  assign out_data = ((BUBBLE_ZERO != 0) && (occupancy == 2'd0)) ? BUBBLE_VAL : main_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a skid instance driven through a scoreboard and a
// single-register instance checked for its combinational ready behaviour.
module tb_pipe_stage_skid;

  localparam int              DW = 64;
  localparam logic [DW-1:0]   BV = 64'h0000_0000_0000_0013;

  logic          clk;
  logic          rst;
  logic          a_flush, a_stall, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [1:0]    a_occ;
  logic          b_flush, b_stall, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [1:0]    b_occ;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_q[$];
  logic [DW-1:0] got_q[$];
  int            spurious;
  int            n_tests;
  int            n_fail;

  pipe_stage_skid #(.DATA_W(DW), .SKID(1), .BUBBLE_ZERO(1), .BUBBLE_VAL(BV)) dut_a (
    .clock(clk), .reset(rst), .flush(a_flush), .stall(a_stall),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .occupancy(a_occ)
  );

  pipe_stage_skid #(.DATA_W(DW), .SKID(0), .BUBBLE_ZERO(0), .BUBBLE_VAL(BV)) dut_b (
    .clock(clk), .reset(rst), .flush(b_flush), .stall(b_stall),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .occupancy(b_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: record skid-instance transfers at the negedge (inputs are stable
  // until the next posedge), then advance to just after the posedge.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      if (a_out_valid && a_out_ready) begin
        got_q.push_back(a_out_data);
        if (exp_q.size() > 0) ref_q.push_back(exp_q.pop_front());
        else spurious++;
      end
      if (a_flush) exp_q.delete();
      else if (a_in_valid && a_in_ready) exp_q.push_back(a_in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sb_clear();
    exp_q.delete();
    ref_q.delete();
    got_q.delete();
    spurious = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_tests++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL rst_occ: got %0d want 0", a_occ); end
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", a_out_valid); end
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready_skid: got %b want 1", a_in_ready); end
    n_tests++; if (a_out_data !== BV) begin n_fail++; $display("FAIL rst_out_data: got %0h want %0h", a_out_data, BV); end
    n_tests++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_noskid: got %b want 0", b_in_ready); end
    n_tests++; if (b_out_data !== BV) begin n_fail++; $display("FAIL rst_out_data_noskid: got %0h want %0h", b_out_data, BV); end
    rst = 1'b0;
    #1;
    n_tests++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready_noskid: got %b want 1", b_in_ready); end
    sb_clear();
  endtask

  task automatic test_backpressure();
    sb_clear();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 64'hA1;
    tick();
    n_tests++; if (a_occ !== 2'd1) begin n_fail++; $display("FAIL bp_occ1: got %0d want 1", a_occ); end
    n_tests++; if (a_out_data !== 64'hA1) begin n_fail++; $display("FAIL bp_head: got %0h want a1", a_out_data); end
    a_in_data = 64'hA2;
    tick();
    n_tests++; if (a_occ !== 2'd2) begin n_fail++; $display("FAIL bp_occ2: got %0d want 2", a_occ); end
    n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full: got %b want 0", a_in_ready); end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    tick();
    n_tests++; if (a_out_data !== 64'hA2) begin n_fail++; $display("FAIL bp_second: got %0h want a2", a_out_data); end
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_reopen: got %b want 1", a_in_ready); end
    tick();
    n_tests++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL bp_drained: got %0d want 0", a_occ); end
    n_tests++; if (a_out_data !== BV) begin n_fail++; $display("FAIL bp_bubble: got %0h want %0h", a_out_data, BV); end
    n_tests++;
    if (got_q.size() != 2 || spurious != 0) begin
      n_fail++; $display("FAIL bp_count: got %0d outputs (%0d spurious) want 2", got_q.size(), spurious);
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (got_q[i] !== ref_q[i]) begin n_fail++; $display("FAIL bp_order[%0d]: got %0h want %0h", i, got_q[i], ref_q[i]); end
      end
      n_tests++; if (got_q[0] !== 64'hA1) begin n_fail++; $display("FAIL bp_first_out: got %0h want a1", got_q[0]); end
    end
    a_out_ready = 1'b0;
  endtask

  task automatic test_stream();
    sb_clear();
    a_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_in_valid = 1'b1; a_in_data = 64'h10 + 64'(i);
      tick();
      n_tests++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL st_valid[%0d]: got %b want 1", i, a_out_valid); end
      n_tests++; if (a_occ !== 2'd1) begin n_fail++; $display("FAIL st_occ[%0d]: got %0d want 1", i, a_occ); end
      n_tests++; if (a_out_data !== 64'h10 + 64'(i)) begin n_fail++; $display("FAIL st_data[%0d]: got %0h want %0h", i, a_out_data, 64'h10 + 64'(i)); end
    end
    a_in_valid = 1'b0;
    tick();
    n_tests++;
    if (got_q.size() != 16 || spurious != 0) begin
      n_fail++; $display("FAIL st_count: got %0d outputs (%0d spurious) want 16", got_q.size(), spurious);
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_tests++;
        if (got_q[i] !== ref_q[i]) begin n_fail++; $display("FAIL st_sb[%0d]: got %0h want %0h", i, got_q[i], ref_q[i]); end
      end
    end
    a_out_ready = 1'b0;
  endtask

  task automatic test_flush();
    sb_clear();
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    a_in_data = 64'hB1; tick();
    a_in_data = 64'hB2; tick();
    n_tests++; if (a_occ !== 2'd2) begin n_fail++; $display("FAIL fl_pre_occ: got %0d want 2", a_occ); end
    a_flush = 1'b1; a_in_data = 64'hFF;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    n_tests++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL fl_occ: got %0d want 0", a_occ); end
    n_tests++; if (a_out_data !== BV) begin n_fail++; $display("FAIL fl_bubble: got %0h want %0h", a_out_data, BV); end
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_in_ready: got %b want 1", a_in_ready); end
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_tests++; if (got_q.size() != 0 || spurious != 0) begin n_fail++; $display("FAIL fl_leak: got %0d outputs want 0", got_q.size() + spurious); end
    a_out_ready = 1'b0;
  endtask

  task automatic test_stall();
    sb_clear();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 64'h55;
    tick();
    a_in_valid = 1'b0; a_stall = 1'b1; a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL sl_valid[%0d]: got %b want 0", i, a_out_valid); end
      n_tests++; if (a_out_data !== 64'h55) begin n_fail++; $display("FAIL sl_hold[%0d]: got %0h want 55", i, a_out_data); end
    end
    a_stall = 1'b0;
    #1;
    n_tests++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL sl_release: got %b want 1", a_out_valid); end
    tick();
    tick();
    n_tests++;
    if (got_q.size() != 1 || spurious != 0) begin
      n_fail++; $display("FAIL sl_once: got %0d outputs want 1", got_q.size() + spurious);
    end else begin
      n_tests++; if (got_q[0] !== 64'h55) begin n_fail++; $display("FAIL sl_value: got %0h want 55", got_q[0]); end
    end
    // upstream keeps filling while the downstream side is frozen
    sb_clear();
    a_stall = 1'b1; a_in_valid = 1'b1;
    a_in_data = 64'h66; tick();
    a_in_data = 64'h67; tick();
    a_in_valid = 1'b0;
    n_tests++; if (a_occ !== 2'd2) begin n_fail++; $display("FAIL sl_fill_occ: got %0d want 2", a_occ); end
    a_stall = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (got_q.size() != 2 || spurious != 0) begin
      n_fail++; $display("FAIL sl_fill_count: got %0d outputs want 2", got_q.size() + spurious);
    end else begin
      n_tests++; if (got_q[0] !== 64'h66 || got_q[1] !== 64'h67) begin n_fail++; $display("FAIL sl_fill_order: got %0h,%0h want 66,67", got_q[0], got_q[1]); end
    end
    a_out_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    sb_clear();
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    a_in_data = 64'hC1; tick();
    a_in_data = 64'hC2; tick();
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    #1;
    n_tests++; if (a_out_valid !== 1'b1 || a_occ !== 2'd2) begin n_fail++; $display("FAIL mr_pre: got valid %b occ %0d want 1/2", a_out_valid, a_occ); end
    rst = 1'b1;
    #1;
    n_tests++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL mr_occ: got %0d want 0", a_occ); end
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_valid: got %b want 0", a_out_valid); end
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL mr_in_ready: got %b want 1", a_in_ready); end
    n_tests++; if (a_out_data !== BV) begin n_fail++; $display("FAIL mr_data: got %0h want %0h", a_out_data, BV); end
    @(posedge clk);
    #1;
    rst = 1'b0; a_out_ready = 1'b0;
    sb_clear();
  endtask

  task automatic test_noskid();
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 64'h77;
    tick();
    n_tests++; if (b_occ !== 2'd1) begin n_fail++; $display("FAIL ns_occ: got %0d want 1", b_occ); end
    n_tests++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL ns_full_ready: got %b want 0", b_in_ready); end
    b_out_ready = 1'b1;
    #1;
    n_tests++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL ns_comb_ready: got %b want 1", b_in_ready); end
    b_in_data = 64'h78;
    tick();
    n_tests++; if (b_out_data !== 64'h78 || b_occ !== 2'd1) begin n_fail++; $display("FAIL ns_pass: got %0h occ %0d want 78/1", b_out_data, b_occ); end
    b_out_ready = 1'b0; b_in_data = 64'h79;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (b_occ > 2'd1 || b_in_ready !== 1'b0) begin n_fail++; $display("FAIL ns_bound[%0d]: got occ %0d ready %b want <=1/0", i, b_occ, b_in_ready); end
      n_tests++; if (b_out_data !== 64'h78) begin n_fail++; $display("FAIL ns_hold[%0d]: got %0h want 78", i, b_out_data); end
    end
    b_stall = 1'b1; b_out_ready = 1'b1;
    #1;
    n_tests++; if (b_in_ready !== 1'b0 || b_out_valid !== 1'b0) begin n_fail++; $display("FAIL ns_stall: got ready %b valid %b want 0/0", b_in_ready, b_out_valid); end
    b_stall = 1'b0; b_in_valid = 1'b0;
    tick();
    n_tests++; if (b_occ !== 2'd0 || b_out_valid !== 1'b0) begin n_fail++; $display("FAIL ns_drain: got occ %0d valid %b want 0/0", b_occ, b_out_valid); end
    n_tests++; if (b_out_data !== 64'h78) begin n_fail++; $display("FAIL ns_keep_last: got %0h want 78", b_out_data); end
    b_out_ready = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; spurious = 0;
    a_flush = 1'b0; a_stall = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_flush = 1'b0; b_stall = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    test_reset();
    test_backpressure();
    test_stream();
    test_flush();
    test_stall();
    test_reset_midstream();
    test_noskid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
